time_set_ctrl: RTL and testbench

Edit controller for the calendar/time counter. It captures the running time into shadow registers and lets the user step through the fields with debounced button pulses, adjusting each field with wrap-around and calendar-correct limits. On commit it issues a one-cycle load to the time counter. It sits between the button debouncers and the time counter; the time counter's `load`/`run_en` inputs are driven only by this block.

---
 rtl/time_set_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// ------------------------------------------------------------------
// Edit controller for the calendar/time counter. On a mode press in
// RUN it snapshots the live time into shadow registers, then walks the
// user through year, month, day, week, hour, minute and second. Each
// field is adjusted with inc/dec presses. Every field wraps at both
// ends, and the day limit follows the calendar. After the second field,
// a final mode press emits a one-cycle load so the counter takes the
// shadow values.
//
// Optional feature macro: TIME_SET_TIMEOUT_EN. When it is defined, an
// edit is abandoned after TIMEOUT_CYCLES cycles with no button press.
// The state returns to RUN, no load is issued and the shadow values are
// left as they are.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   btn_mode/inc/dec         one-cycle debounced button pulses
//   cur_*                    live time-counter values
//   set_*                    shadow (edited) values
//   load                     one-cycle pulse: the counter copies set_*
//   run_en                   high while the counter may advance
//   field                    selected field (0 none, 1..7 year..second)
//
// Handshake: the buttons are fire-and-forget pulses with no ready. In
// a single cycle mode beats inc, and inc beats dec. The lower-priority
// pulse is dropped. load is a pulse with no acknowledge.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 30_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  input  logic [10:0] cur_week,
  output logic [15:0] set_year,
  output logic [5:0]  set_month,
  output logic [10:0] set_day,
  output logic [10:0] set_hour,
  output logic [10:0] set_minute,
  output logic [10:0] set_second,
  output logic [10:0] set_week,
  output logic        load,
  output logic        run_en,
  output logic [2:0]  field
);

  typedef enum logic [3:0] {
    RUN    = 4'd0,
    EYEAR  = 4'd1,
    EMONTH = 4'd2,
    EDAY   = 4'd3,
    EWEEK  = 4'd4,
    EHOUR  = 4'd5,
    EMIN   = 4'd6,
    ESEC   = 4'd7,
    COMMIT = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] year_q, year_d;
  logic [5:0]  month_q, month_d;
  logic [10:0] day_q, day_d, hour_q, hour_d, min_q, min_d;
  logic [10:0] sec_q, sec_d, week_q, week_d;
  logic        is_edit;

  // Days in a month. A month value that is out of range cannot come
  // from editing, so it gets the widest limit (31).
  function automatic logic [10:0] mdays(input logic [15:0] y, input logic [5:0] m);
    logic leap;
    leap = (y % 16'd4 == 16'd0) && ((y % 16'd100 != 16'd0) || (y % 16'd400 == 16'd0));
    case (m)
      6'd4, 6'd6, 6'd9, 6'd11: mdays = 11'd30;
      6'd2:                    mdays = leap ? 11'd29 : 11'd28;
      default:                 mdays = 11'd31;
    endcase
  endfunction

  // Wrap-around step. A value outside [lo,hi] (for example a raw value
  // captured from the counter) snaps to lo on the first press.
  function automatic logic [15:0] adj(input logic [15:0] v, input logic [15:0] lo,
                                      input logic [15:0] hi, input logic up);
    if (v < lo || v > hi) adj = lo;
    else if (up)          adj = (v == hi) ? lo : v + 16'd1;
    else                  adj = (v == lo) ? hi : v - 16'd1;
  endfunction

  function automatic logic [10:0] min11(input logic [10:0] a, input logic [10:0] b);
    min11 = (a < b) ? a : b;
  endfunction

  assign is_edit = (state_q != RUN) && (state_q != COMMIT);

`ifdef TIME_SET_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        to_hit;
  assign to_hit = (to_cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    to_cnt_q <= 32'd0;
    else if (!is_edit)                          to_cnt_q <= 32'd0;
    else if (btn_mode || btn_inc || btn_dec || to_hit) to_cnt_q <= 32'd0;
    else                                        to_cnt_q <= to_cnt_q + 32'd1;
  end
`else
  logic to_hit;
  logic unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    logic [15:0] tmp;
    logic        up;
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    week_d  = week_q;
    tmp     = 16'd0;
    up      = btn_inc;
    case (state_q)
      RUN: begin
        if (btn_mode) begin
          year_d  = cur_year;
          month_d = cur_month;
          day_d   = cur_day;
          hour_d  = cur_hour;
          min_d   = cur_minute;
          sec_d   = cur_second;
          week_d  = cur_week;
          state_d = EYEAR;
        end
      end
      COMMIT: state_d = RUN;
      default: begin
        // A button press in the same cycle keeps the edit alive.
        if (to_hit && !(btn_mode || btn_inc || btn_dec)) begin
          state_d = RUN;
        end else if (btn_mode) begin
          state_d = state_e'(state_q + 4'd1);
        end else if (btn_inc || btn_dec) begin
          case (state_q)
            EYEAR: begin
              year_d = adj(year_q, 16'd2000, 16'd2099, up);
              day_d  = min11(day_q, mdays(year_d, month_q));
            end
            EMONTH: begin
              tmp     = adj({10'd0, month_q}, 16'd1, 16'd12, up);
              month_d = tmp[5:0];
              day_d   = min11(day_q, mdays(year_q, month_d));
            end
            EDAY: begin
              tmp   = adj({5'd0, day_q}, 16'd1, {5'd0, mdays(year_q, month_q)}, up);
              day_d = tmp[10:0];
            end
            EWEEK: begin
              tmp    = adj({5'd0, week_q}, 16'd1, 16'd7, up);
              week_d = tmp[10:0];
            end
            EHOUR: begin
              tmp    = adj({5'd0, hour_q}, 16'd0, 16'd23, up);
              hour_d = tmp[10:0];
            end
            EMIN: begin
              tmp   = adj({5'd0, min_q}, 16'd0, 16'd59, up);
              min_d = tmp[10:0];
            end
            default: begin
              tmp   = adj({5'd0, sec_q}, 16'd0, 16'd59, up);
              sec_d = tmp[10:0];
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      year_q  <= 16'd2023;
      month_q <= 6'd5;
      day_q   <= 11'd9;
      week_q  <= 11'd2;
      hour_q  <= 11'd0;
      min_q   <= 11'd0;
      sec_q   <= 11'd0;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      week_q  <= week_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign set_year   = year_q;
  assign set_month  = month_q;
  assign set_day    = day_q;
  assign set_hour   = hour_q;
  assign set_minute = min_q;
  assign set_second = sec_q;
  assign set_week   = week_q;
  assign load       = (state_q == COMMIT);
  assign run_en     = (state_q == RUN);
  assign field      = is_edit ? state_q[2:0] : 3'd0;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

`ifdef TIME_SET_TIMEOUT_EN
  localparam int  TO    = 16;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  TO    = 30_000_000;
  localparam bit  TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [15:0] cur_year = '0;
  logic [5:0]  cur_month = '0;
  logic [10:0] cur_day = '0, cur_hour = '0, cur_minute = '0, cur_second = '0, cur_week = '0;
  logic [15:0] set_year;
  logic [5:0]  set_month;
  logic [10:0] set_day, set_hour, set_minute, set_second, set_week;
  logic        load, run_en;
  logic [2:0]  field;

  time_set_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .cur_week(cur_week),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set_week(set_week),
    .load(load), .run_en(run_en), .field(field)
  );

  // ---------------- behavioural model ----------------
  // m_mode: 0 = running, 1..7 = editing that field, 8 = commit cycle.
  // Field index: 1 year, 2 month, 3 day, 4 week, 5 hour, 6 minute, 7 second.
  int m_mode;
  int m_val[1:7];
  int c_val[1:7];
  int m_idle;
  int n_vec  = 0;
  int n_fail = 0;

  function automatic int days_in(int y, int m);
    int tbl[1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (m < 1 || m > 12) return 31;
    if (m == 2 && leap) return 29;
    return tbl[m];
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_idle = 0;
    m_val  = '{2023, 5, 9, 2, 0, 0, 0};
  endtask

  task automatic model_adjust(int f, int dir);
    int lo, hi, span;
    case (f)
      1: begin lo = 2000; hi = 2099; end
      2: begin lo = 1;    hi = 12;   end
      3: begin lo = 1;    hi = days_in(m_val[1], m_val[2]); end
      4: begin lo = 1;    hi = 7;    end
      5: begin lo = 0;    hi = 23;   end
      default: begin lo = 0; hi = 59; end
    endcase
    span = hi - lo + 1;
    if (m_val[f] < lo || m_val[f] > hi) m_val[f] = lo;
    else m_val[f] = lo + ((m_val[f] - lo + dir + span) % span);
    if (f <= 2 && m_val[3] > days_in(m_val[1], m_val[2]))
      m_val[3] = days_in(m_val[1], m_val[2]);
  endtask

  task automatic model_step(bit bm, bit bi, bit bd);
    if (m_mode == 0) begin
      m_idle = 0;
      if (bm) begin
        for (int i = 1; i <= 7; i++) m_val[i] = c_val[i];
        m_mode = 1;
      end
    end else if (m_mode == 8) begin
      m_mode = 0;
      m_idle = 0;
    end else if (TO_EN && !(bm || bi || bd) && m_idle == TO - 1) begin
      m_mode = 0;
      m_idle = 0;
    end else begin
      if (bm || bi || bd) m_idle = 0;
      else                m_idle++;
      if (bm)      m_mode++;
      else if (bi) model_adjust(m_mode, 1);
      else if (bd) model_adjust(m_mode, -1);
      if (m_mode == 8) m_idle = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("field",  int'(field),  (m_mode >= 1 && m_mode <= 7) ? m_mode : 0);
    chk("load",   int'(load),   (m_mode == 8) ? 1 : 0);
    chk("run_en", int'(run_en), (m_mode == 0) ? 1 : 0);
    chk("set_year",   int'(set_year),   m_val[1]);
    chk("set_month",  int'(set_month),  m_val[2]);
    chk("set_day",    int'(set_day),    m_val[3]);
    chk("set_week",   int'(set_week),   m_val[4]);
    chk("set_hour",   int'(set_hour),   m_val[5]);
    chk("set_minute", int'(set_minute), m_val[6]);
    chk("set_second", int'(set_second), m_val[7]);
  endtask

  // ---------------- driver ----------------
  task automatic drive_cur();
    cur_year   = 16'(c_val[1]);
    cur_month  = 6'(c_val[2]);
    cur_day    = 11'(c_val[3]);
    cur_week   = 11'(c_val[4]);
    cur_hour   = 11'(c_val[5]);
    cur_minute = 11'(c_val[6]);
    cur_second = 11'(c_val[7]);
  endtask

  task automatic step(bit bm, bit bi, bit bd);
    @(negedge clk);
    drive_cur();
    btn_mode = bm; btn_inc = bi; btn_dec = bd;
    model_step(bm, bi, bd);
    @(posedge clk);
    #1;
    check_all();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    c_val = '{2024, 2, 29, 4, 12, 34, 56};
    drive_cur();
    #12;
    check_all();
    chk("rst_year_lit", int'(set_year), 2023);
    chk("rst_day_lit",  int'(set_day), 9);
    chk("rst_week_lit", int'(set_week), 2);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);

    // Full walk: capture, seven fields, commit.
    for (int i = 1; i <= 7; i++) begin
      step(1, 0, 0);
      chk("walk_field_lit", int'(field), i);
    end
    chk("cap_year_lit", int'(set_year), 2024);
    chk("cap_sec_lit",  int'(set_second), 56);
    step(1, 0, 0);
    chk("commit_load_lit", int'(load), 1);
    chk("commit_runen_lit", int'(run_en), 0);
    step(0, 0, 0);
    chk("after_commit_runen_lit", int'(run_en), 1);
    chk("after_commit_load_lit",  int'(load), 0);

    // Leap clamp, hour/minute wrap, mode-beats-inc.
    c_val = '{2024, 2, 29, 4, 23, 0, 56};
    step(1, 0, 0);
    step(0, 1, 0);
    chk("year_inc_lit", int'(set_year), 2025);
    chk("day_clamp_lit", int'(set_day), 28);
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("mode_beats_inc_month_lit", int'(set_month), 2);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("hour_wrap_up_lit", int'(set_hour), 0);
    step(0, 0, 1);
    chk("hour_wrap_dn_lit", int'(set_hour), 23);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("min_wrap_dn_lit", int'(set_minute), 59);

    // Asynchronous reset while editing minutes.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_mid_runen_lit", int'(run_en), 1);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);

    if (TO_EN) begin
      step(1, 0, 0);
      for (int i = 0; i < TO; i++) step(0, 0, 0);
      chk("timeout_runen_lit", int'(run_en), 1);
    end

    // Random phase: fresh counter values every cycle, some out of range.
    for (int n = 0; n < 3000; n++) begin
      c_val[1] = $urandom_range(2110, 1990);
      c_val[2] = $urandom_range(12, 1);
      c_val[3] = $urandom_range(33, 0);
      c_val[4] = $urandom_range(8, 0);
      c_val[5] = $urandom_range(25, 0);
      c_val[6] = $urandom_range(61, 0);
      c_val[7] = $urandom_range(61, 0);
      step($urandom_range(9, 0) == 0, $urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
